// File: rtl/midi_voice_pkg.sv
// Shared constants and FSM encoding for the MIDI voice allocator.
package midi_voice_pkg;

  localparam logic [7:0] NOTE_MIN = 8'd23;
  localparam logic [7:0] NOTE_MAX = 8'd111;
  localparam int         AGE_W    = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MATCH  = 2'd1,
    ST_COMMIT = 2'd2
  } state_t;

  function automatic logic note_in_range(input logic [7:0] note);
    return (note >= NOTE_MIN) && (note <= NOTE_MAX);
  endfunction

endpackage

// File: rtl/midi_voice_select.sv
// Combinational priority selection: voices matching a key, lowest free voice,
// and the oldest voice (largest age, ties to the lowest index).
module midi_voice_select
  import midi_voice_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int IDX_W      = 2
) (
  input  logic [NUM_VOICES-1:0]       active,
  input  logic [8*NUM_VOICES-1:0]     notes,
  input  logic [AGE_W*NUM_VOICES-1:0] ages,
  input  logic [7:0]                  key,
  output logic [NUM_VOICES-1:0]       match_mask,
  output logic                        match_hit,
  output logic [IDX_W-1:0]            match_idx,
  output logic                        free_hit,
  output logic [IDX_W-1:0]            free_idx,
  output logic [IDX_W-1:0]            oldest_idx
);

  logic [AGE_W-1:0] best_age;

  always_comb begin
    match_mask = '0;
    match_hit  = 1'b0;
    match_idx  = '0;
    free_hit   = 1'b0;
    free_idx   = '0;
    oldest_idx = '0;
    best_age   = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (active[i] && (notes[8*i +: 8] == key)) begin
        match_mask[i] = 1'b1;
        if (!match_hit) begin
          match_hit = 1'b1;
          match_idx = IDX_W'(i);
        end
      end
      if (!active[i] && !free_hit) begin
        free_hit = 1'b1;
        free_idx = IDX_W'(i);
      end
      // Strict compare keeps the lowest index on equal ages.
      if (ages[AGE_W*i +: AGE_W] > best_age) begin
        best_age   = ages[AGE_W*i +: AGE_W];
        oldest_idx = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/midi_voice_alloc.sv
// MIDI note-to-voice allocator: IDLE -> MATCH -> COMMIT pipeline over NUM_VOICES voices.
// Voice stealing when all voices sound is compiled in with MIDI_VOICE_STEAL_EN.
module midi_voice_alloc
  import midi_voice_pkg::*;
#(
  parameter int NUM_VOICES = 4
) (
  input  logic                    Clk,
  input  logic                    Rst_n,
  input  logic                    noteValid,
  output logic                    noteReady,
  input  logic                    noteOn,
  input  logic [7:0]              noteNum,
  input  logic [7:0]              noteVel,
  input  logic                    panic,
  output logic [16*NUM_VOICES-1:0] voiceData,
  output logic [NUM_VOICES-1:0]   voiceActive,
  output logic                    dropped
);

  localparam int IDX_W = $clog2(NUM_VOICES);

  state_t state, state_nxt;
  logic   accept;

  logic       cap_on;
  logic [7:0] cap_note;
  logic [7:0] cap_vel;

  logic [7:0]       v_note [NUM_VOICES];
  logic [7:0]       v_vel  [NUM_VOICES];
  logic [AGE_W-1:0] v_age  [NUM_VOICES];
  logic [NUM_VOICES-1:0] v_active;

  logic [8*NUM_VOICES-1:0]     notes_flat;
  logic [AGE_W*NUM_VOICES-1:0] ages_flat;

  logic [NUM_VOICES-1:0] sel_mask, r_mask;
  logic                  sel_match_hit, sel_free_hit, r_match_hit, r_free_hit;
  logic [IDX_W-1:0]      sel_match_idx, sel_free_idx, sel_oldest_idx;
  logic [IDX_W-1:0]      r_match_idx, r_free_idx, r_oldest_idx;

  logic             do_drop, do_load, do_off;
  logic [IDX_W-1:0] tgt_idx;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    unique case (state)
      ST_IDLE: if (noteValid) begin
        accept    = 1'b1;
        state_nxt = ST_MATCH;
      end
      ST_MATCH:  state_nxt = ST_COMMIT;
      ST_COMMIT: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
    if (panic) begin
      accept    = 1'b0;
      state_nxt = ST_IDLE;
    end
  end

  assign noteReady = (state == ST_IDLE);

  always_comb begin
    notes_flat = '0;
    ages_flat  = '0;
    voiceData  = '0;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      notes_flat[8*i +: 8]         = v_note[i];
      ages_flat[AGE_W*i +: AGE_W]  = v_age[i];
      voiceData[16*i +: 16]        = {v_note[i], v_vel[i]};
    end
  end

  assign voiceActive = v_active;

  midi_voice_select #(
    .NUM_VOICES (NUM_VOICES),
    .IDX_W      (IDX_W)
  ) u_select (
    .active     (v_active),
    .notes      (notes_flat),
    .ages       (ages_flat),
    .key        (cap_note),
    .match_mask (sel_mask),
    .match_hit  (sel_match_hit),
    .match_idx  (sel_match_idx),
    .free_hit   (sel_free_hit),
    .free_idx   (sel_free_idx),
    .oldest_idx (sel_oldest_idx)
  );

  // Commit decision; the steal target defaults to the oldest voice and is
  // only loaded when stealing is compiled in.
  always_comb begin
    do_drop = 1'b0;
    do_load = 1'b0;
    do_off  = 1'b0;
    tgt_idx = r_oldest_idx;
    if (!note_in_range(cap_note)) begin
      do_drop = 1'b1;
    end else if (!cap_on || (cap_vel == '0)) begin
      do_off = 1'b1;
    end else if (r_match_hit) begin
      do_load = 1'b1;
      tgt_idx = r_match_idx;
    end else if (r_free_hit) begin
      do_load = 1'b1;
      tgt_idx = r_free_idx;
    end else begin
`ifdef MIDI_VOICE_STEAL_EN
      do_load = 1'b1;
`else
      do_drop = 1'b1;
`endif
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cap_on       <= 1'b0;
      cap_note     <= '0;
      cap_vel      <= '0;
      r_mask       <= '0;
      r_match_hit  <= 1'b0;
      r_match_idx  <= '0;
      r_free_hit   <= 1'b0;
      r_free_idx   <= '0;
      r_oldest_idx <= '0;
      v_active     <= '0;
      dropped      <= 1'b0;
      for (int unsigned i = 0; i < NUM_VOICES; i++) begin
        v_note[i] <= '0;
        v_vel[i]  <= '0;
        v_age[i]  <= '0;
      end
    end else begin
      dropped <= 1'b0;
      if (panic) begin
        v_active <= '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
          v_note[i] <= '0;
          v_vel[i]  <= '0;
          v_age[i]  <= '0;
        end
      end else begin
        if (accept) begin
          cap_on   <= noteOn;
          cap_note <= noteNum;
          cap_vel  <= noteVel;
        end
        if (state == ST_MATCH) begin
          r_mask       <= sel_mask;
          r_match_hit  <= sel_match_hit;
          r_match_idx  <= sel_match_idx;
          r_free_hit   <= sel_free_hit;
          r_free_idx   <= sel_free_idx;
          r_oldest_idx <= sel_oldest_idx;
        end
        if (state == ST_COMMIT) begin
          dropped <= do_drop;
          for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (do_load) begin
              if (IDX_W'(i) == tgt_idx) begin
                v_note[i]   <= cap_note;
                v_vel[i]    <= cap_vel;
                v_age[i]    <= '0;
                v_active[i] <= 1'b1;
              end else if (v_active[i] && (v_age[i] != '1)) begin
                v_age[i] <= v_age[i] + AGE_W'(1);
              end
            end
            if (do_off && r_mask[i]) begin
              v_note[i]   <= '0;
              v_vel[i]    <= '0;
              v_age[i]    <= '0;
              v_active[i] <= 1'b0;
            end
          end
        end
      end
    end
  end

endmodule

// File: doc/midi_voice_alloc.md
MIDI_VOICE_ALLOC -- requirements
Module: midi_voice_alloc

Interface
REQ-001 SHALL have parameter NUM_VOICES, default 4, meaning the number of stepper voices (2..8).
REQ-002 SHALL have port Clk  input  1  system clock, 50 MHz.
REQ-003 SHALL have port Rst_n  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port noteValid  input  1  MIDI event present; transfers when noteValid && noteReady.
REQ-005 SHALL have port noteReady  output  1  allocator idle, able to accept an event.
REQ-006 SHALL have port noteOn  input  1  1 = note-on, 0 = note-off.
REQ-007 SHALL have port noteNum  input  8  MIDI note number.
REQ-008 SHALL have port noteVel  input  8  MIDI velocity.
REQ-009 SHALL have port panic  input  1  all-notes-off request.
REQ-010 SHALL have port voiceData  output  16*NUM_VOICES  per-voice {note[15:8], velocity[7:0]}; voice i occupies bits [16i+15:16i] and feeds one pitch converter.
REQ-011 SHALL have port voiceActive  output  NUM_VOICES  per-voice sounding flag.
REQ-012 SHALL have port dropped  output  1  one-cycle pulse when an event is discarded.

Function
REQ-013 SHALL use an FSM with states IDLE -> MATCH -> COMMIT -> IDLE; noteReady SHALL be high only in IDLE.
REQ-014 SHALL capture noteOn, noteNum and noteVel on the accepting edge (cycle 0); MATCH is cycle 1 and COMMIT is cycle 2.
REQ-015 SHALL make voiceData, voiceActive and dropped reflect the event in cycle 3, with noteReady high again in cycle 3.
REQ-016 SHALL treat a note-on with velocity 0 as a note-off.
REQ-017 SHALL, for a note-on whose note already sounds in voice i, retrigger voice i: update its velocity and reset its age to 0.
REQ-018 SHALL, otherwise, allocate the lowest-index inactive voice: load {note, vel}, set active, set age 0.
REQ-019 SHALL keep a saturating per-voice age counter of width AGE_W = 8; at every committed note-on, every active voice other than the target increments its age, saturating at 255.
REQ-020 SHALL, when all voices are active, follow the full-voice rule in REQ-031.
REQ-021 SHALL, on a note-off, clear active on every voice holding that note and zero that voice's voiceData; a note-off with no match is silently ignored, with no dropped pulse.
REQ-022 SHALL discard any event with noteNum < NOTE_MIN (23) or > NOTE_MAX (111), pulsing dropped in cycle 3 and leaving all voices unchanged.
REQ-023 SHALL give an inactive voice voiceData = 0, which makes its pitch converter output 0.
REQ-024 SHALL, when panic is sampled high in any state, on that edge clear all voices and ages, force IDLE, and discard any in-flight event without a dropped pulse; panic SHALL override noteValid in the same cycle.
REQ-025 SHALL ignore noteValid and hold the captured event while noteReady is low.

Reset
REQ-026 SHALL, while Rst_n is low, asynchronously force: state IDLE, noteReady 1, voiceData 0, voiceActive 0, dropped 0, all ages 0, capture registers 0.
REQ-027 SHALL abandon any event in flight when reset is asserted mid-operation; the event SHALL NOT commit after reset release.
REQ-028 SHALL accept the first event on the first Clk edge after Rst_n deasserts.

Configuration
REQ-029 SHALL support voice stealing, compiled in with macro MIDI_VOICE_STEAL_EN.
REQ-030 SHALL, with MIDI_VOICE_STEAL_EN defined and all voices active, steal the voice with the largest age (ties go to the lowest index), load the new note into it with age 0, and pulse no dropped.
REQ-031 SHALL, without MIDI_VOICE_STEAL_EN defined and all voices active, discard the new note-on and pulse dropped in cycle 3.

Structure
REQ-032 SHALL place NOTE_MIN, NOTE_MAX, AGE_W and the FSM state encoding in the shared package midi_voice_pkg.
REQ-033 SHALL implement match, free and oldest priority selection in one combinational sub-module, midi_voice_select, instantiated once and registered in MATCH.

Verification
REQ-034 SHALL cover: with NUM_VOICES=4, note-on 60/100 then note-on 64/90 -> voice0={60,100} and voice1={64,90} active, each visible 3 cycles after acceptance.
REQ-035 SHALL cover: note-on 60/100, then note-on 60/0 -> voice0 inactive and voiceData[15:0]=0; a further note-off 72 -> no change and no dropped pulse.
REQ-036 SHALL cover: notes 60, 62, 64, 65, then 67 -> with MIDI_VOICE_STEAL_EN, voice0={67,vel} and dropped=0; without the macro, voices unchanged and dropped pulses once.
REQ-037 SHALL cover: note-on 20/80 and note-on 112/80 -> dropped pulses for each, voiceActive stays 0.
REQ-038 SHALL cover: noteValid asserted in cycle 1 of the MATCH state for note 60 -> event ignored; note 62 retriggered while sounding -> same voice, age 0, velocity updated.
REQ-039 SHALL cover: panic asserted during COMMIT of note 60, and Rst_n pulsed low during MATCH -> all voices 0, IDLE next cycle, no commit of note 60, noteReady=1.
